wts_channel_mixer_5ch: RTL
==========================

Name: wts_channel_mixer_5ch

Overview:
Downstream consumer of the 5-channel time-multiplexed ADSR envelope generator. In each slot it takes the active channel's wave sample and envelope level, scales them by the channel volume, and accumulates the five channel terms. On the end-of-frame slot it emits one saturated mixed sample. The block is a 3-stage pipeline whose slot tag travels alongside the data.

Parameters:
OUT_WIDTH, 12, width of the signed saturated mix output.
VOL_SHIFT, 8, arithmetic right shift applied after the volume multiply.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
active  input  3  slot index: 0..4 = channel A..E, 5 = end of frame, 6/7 = no operation
envelope  input  7  unsigned envelope level of the active channel, aligned with active
wave_sample  input  8  signed two's-complement wave sample of the active channel, aligned with active
reg_volume_a..reg_volume_e  input  4 each  unsigned channel volume, 0..15
ch_a_enable..ch_e_enable  input  1 each  channel enable; 0 mutes the channel
mix_out  output  OUT_WIDTH  signed mixed sample, held between frames
mix_valid  output  1  one-cycle pulse, high when mix_out has just been updated

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (reset sampled high at a rising edge of clk).
- Reset effects: both pipeline tags are forced to 3'd7 (no-op); data registers, accumulator, mix_out and mix_valid all go to 0.
- Reset mid-frame: terms already accumulated are discarded. The next slot-5 tag outputs only the terms accumulated after reset.
- Stage 1 (edge n):
  - tag1 <= active.
  - p1 <= wave_sample (signed) * {1'b0, envelope}, 15-bit signed, range -16256..16129.
  - volume and enable are selected by active in this same cycle.
  - For a disabled channel, or active >= 5, p1 <= 0.
- Stage 2 (edge n+1):
  - tag2 <= tag1.
  - q2 <= (p1 * volume) >>> VOL_SHIFT, 11-bit signed. The shift floors toward minus infinity.
- Stage 3 (edge n+2), by tag2:
  - 0..4: acc <= sat16(acc + q2). acc is 16-bit signed and saturates at -32768/32767.
  - 5: mix_out <= sat_OUT_WIDTH(acc), clamped to [-2048, 2047] at default; acc <= 0; mix_valid <= 1.
  - 6/7: acc holds; mix_valid <= 0.
  - mix_valid is 0 for every tag other than 5.
- Latency: active=5 sampled at edge n gives mix_valid high for exactly the cycle after edge n+2, and mix_out updates at that same edge. A slot's term must enter stage 1 before the slot-5 tag to appear in that frame.
- No frame-order checking:
  - A repeated slot index accumulates twice.
  - A missing slot index contributes nothing.
  - Consecutive slot-5 tags output acc then 0.
- Back-to-back frames: the slot-5 clear and a slot-0 term arriving on the very next edge never collide, because the pipeline carries one tag per edge.
- Volume and enable changes take effect from the next stage-1 sample. Terms already in flight are unaffected.

Test Plan:
1. Reset high for 2 edges, then low with active=7 -> mix_out=0, mix_valid=0, no pulses.
2. Ch A: sample=127, env=127, vol=15, enabled; other channels env=0; active sequence 0,1,2,3,4,5 -> 16129*15=241935, >>>8 = 945; mix_out=945 with mix_valid pulse 2 edges after slot 5 is sampled.
3. Ch A: sample=-128, env=127, vol=15 -> -243840 >>>8 = -953 (floor); mix_out=-953.
4. All five channels at 127/127/15 -> sum 4725 saturates to mix_out=2047; all at -128/127/15 -> sum -4765 saturates to mix_out=-2048.
5. Ch C at 127/127/15 with ch_c_enable=0, and ch D at 127/127 with vol=0 -> both contribute 0. Slots 6/7 interleaved in the frame change nothing; a second consecutive slot 5 gives mix_out=0 with mix_valid pulse.
6. Mid-frame reset after slots 0..2 (each term 945), then slots 3,4,5 with ch D=945 only -> mix_out=945, not 3780.

Source files
------------

// File: rtl/wts_channel_mixer_5ch_if.sv
// Slot bus between the envelope generator and the 5-channel mixer.
// The master drives slot data; the slave returns the mixed sample.
interface wts_channel_mixer_5ch_if #(
   parameter int unsigned OUT_WIDTH = 12
);
   logic [2:0]           active;
   logic [6:0]           envelope;
   logic [7:0]           wave_sample;
   logic [OUT_WIDTH-1:0] mix_out;
   logic                 mix_valid;

   modport master (
      output active,
      output envelope,
      output wave_sample,
      input  mix_out,
      input  mix_valid
   );

   modport slave (
      input  active,
      input  envelope,
      input  wave_sample,
      output mix_out,
      output mix_valid
   );
endinterface

// File: rtl/wts_channel_mixer_5ch.sv
// Five-channel time-multiplexed mixer: 3-stage scale/volume/accumulate pipeline
// with a slot tag carried alongside the data; emits a saturated sample per frame.
module wts_channel_mixer_5ch #(
   parameter int unsigned OUT_WIDTH = 12,
   parameter int unsigned VOL_SHIFT = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [3:0]            reg_volume_a,
   input  logic [3:0]            reg_volume_b,
   input  logic [3:0]            reg_volume_c,
   input  logic [3:0]            reg_volume_d,
   input  logic [3:0]            reg_volume_e,
   input  logic                  ch_a_enable,
   input  logic                  ch_b_enable,
   input  logic                  ch_c_enable,
   input  logic                  ch_d_enable,
   input  logic                  ch_e_enable,
   wts_channel_mixer_5ch_if.slave bus
);

   localparam int unsigned P1_W   = 15;
   localparam int unsigned PROD_W = 20;
   localparam int unsigned Q2_W   = 11;
   localparam int unsigned ACC_W  = 16;
   localparam int unsigned SUM_W  = ACC_W + 1;

   localparam logic [2:0] TAG_EOF = 3'd5;
   localparam logic [2:0] TAG_NOP = 3'd7;

   localparam int OUT_MAX_I = int'((2 ** (OUT_WIDTH - 1)) - 1);
   localparam int OUT_MIN_I = -OUT_MAX_I - 1;
   localparam logic signed [ACC_W-1:0] OUT_MAX_S = ACC_W'(OUT_MAX_I);
   localparam logic signed [ACC_W-1:0] OUT_MIN_S = ACC_W'(OUT_MIN_I);
   localparam logic signed [SUM_W-1:0] SUM_MAX_S = 17'sd32767;
   localparam logic signed [SUM_W-1:0] SUM_MIN_S = -17'sd32768;

   // Stage 1 registers
   logic [2:0]              tag1;
   logic signed [P1_W-1:0]  p1;
   logic [3:0]              vol1;

   // Stage 2 registers
   logic [2:0]              tag2;
   logic signed [Q2_W-1:0]  q2;

   // Stage 3 state
   logic signed [ACC_W-1:0] acc;

   logic [3:0]              vol_sel_c;
   logic                    en_sel_c;
   logic signed [7:0]       wave_s_c;
   logic signed [P1_W-1:0]  wave_ext_c;
   logic signed [P1_W-1:0]  env_ext_c;
   logic signed [P1_W-1:0]  p1_c;
   logic signed [PROD_W-1:0] prod2_c;
   logic signed [SUM_W-1:0] sum_c;
   logic signed [ACC_W-1:0] acc_sat_c;
   logic [OUT_WIDTH-1:0]    mix_sat_c;

   // Per-slot volume/enable select; slots 5..7 are muted
   always_comb begin
      vol_sel_c = 4'd0;
      en_sel_c  = 1'b0;
      case (bus.active)
         3'd0: begin vol_sel_c = reg_volume_a; en_sel_c = ch_a_enable; end
         3'd1: begin vol_sel_c = reg_volume_b; en_sel_c = ch_b_enable; end
         3'd2: begin vol_sel_c = reg_volume_c; en_sel_c = ch_c_enable; end
         3'd3: begin vol_sel_c = reg_volume_d; en_sel_c = ch_d_enable; end
         3'd4: begin vol_sel_c = reg_volume_e; en_sel_c = ch_e_enable; end
         default: ;
      endcase
   end

   assign wave_s_c   = bus.wave_sample;
   assign wave_ext_c = P1_W'(wave_s_c);
   assign env_ext_c  = P1_W'({1'b0, bus.envelope});
   assign p1_c       = wave_ext_c * env_ext_c;

   always_ff @(posedge clk) begin
      if (reset) begin
         tag1 <= TAG_NOP;
         p1   <= '0;
         vol1 <= '0;
      end else begin
         tag1 <= bus.active;
         vol1 <= vol_sel_c;
         p1   <= en_sel_c ? p1_c : '0;
      end
   end

   // Volume scaling; >>> on the signed product floors toward minus infinity
   assign prod2_c = PROD_W'(p1) * PROD_W'($signed({1'b0, vol1}));

   always_ff @(posedge clk) begin
      if (reset) begin
         tag2 <= TAG_NOP;
         q2   <= '0;
      end else begin
         tag2 <= tag1;
         q2   <= Q2_W'(prod2_c >>> VOL_SHIFT);
      end
   end

   assign sum_c = SUM_W'(acc) + SUM_W'(q2);

   always_comb begin
      acc_sat_c = ACC_W'(sum_c);
      if (sum_c > SUM_MAX_S)      acc_sat_c = ACC_W'(SUM_MAX_S);
      else if (sum_c < SUM_MIN_S) acc_sat_c = ACC_W'(SUM_MIN_S);
   end

   always_comb begin
      mix_sat_c = OUT_WIDTH'(acc);
      if (acc > OUT_MAX_S)      mix_sat_c = OUT_WIDTH'(OUT_MAX_S);
      else if (acc < OUT_MIN_S) mix_sat_c = OUT_WIDTH'(OUT_MIN_S);
   end

   // Accumulate channel terms; end-of-frame tag publishes and clears
   always_ff @(posedge clk) begin
      if (reset) begin
         acc           <= '0;
         bus.mix_out   <= '0;
         bus.mix_valid <= 1'b0;
      end else begin
         bus.mix_valid <= 1'b0;
         case (tag2)
            3'd0, 3'd1, 3'd2, 3'd3, 3'd4: acc <= acc_sat_c;
            TAG_EOF: begin
               bus.mix_out   <= mix_sat_c;
               bus.mix_valid <= 1'b1;
               acc           <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule
